// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for a progressive video mode.
// Walks a pixel position across H_TOTAL x V_TOTAL. It produces registered
// syncs, blanking, line/frame strobes and a completed-frame counter. All
// registered outputs in a given cycle describe the pixel at
// (hcount_out, vcount_out).
module video_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   H_W      = 11,
  parameter int   V_W      = 10,
  parameter int   F_W      = 8
) (
  input  logic           pixel_clk_in,
  input  logic           rst_in,
  input  logic           en_in,
  output logic [H_W-1:0] hcount_out,
  output logic [V_W-1:0] vcount_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           blank_out,
  output logic           line_start_out,
  output logic           frame_start_out,
  output logic [F_W-1:0] frame_count_out
);

  // Totals are summed in 32-bit ints so that no parameter sum is truncated.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Elaboration guards: every region must be non-empty, and the counters
  // must be able to hold every position of the raster.
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0) begin : g_bad_h
    $error("video_timing_gen: horizontal active/porch/sync must be non-zero");
  end
  if (V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_v
    $error("video_timing_gen: vertical active/porch/sync must be non-zero");
  end
  if (64'(H_TOTAL) > (64'd1 << H_W)) begin : g_bad_hw
    $error("video_timing_gen: H_TOTAL does not fit in H_W bits");
  end
  if (64'(V_TOTAL) > (64'd1 << V_W)) begin : g_bad_vw
    $error("video_timing_gen: V_TOTAL does not fit in V_W bits");
  end

  // Region boundaries. Each one is < TOTAL, which the guards above bound
  // by 2^W, so casting to the counter width is lossless.
  localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_FIRST  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           h_wrap;
  logic           frame_wrap;
  logic           blank_next;
  logic           hsync_next;
  logic           vsync_next;

  // Next raster position; vcount only moves when the line wraps.
  always_comb begin
    h_wrap     = (hcount_out == H_LAST);
    frame_wrap = h_wrap && (vcount_out == V_LAST);
    h_next     = h_wrap ? '0 : hcount_out + H_W'(1);
    v_next     = vcount_out;
    if (h_wrap) v_next = (vcount_out == V_LAST) ? '0 : vcount_out + V_W'(1);
  end

  // Decode the next position so the registered outputs line up with the
  // registered counters. vsync depends on the line only, so it covers
  // whole lines, including the blanked pixels.
  always_comb begin
    blank_next = (h_next >= H_ACT_END) || (v_next >= V_ACT_END);
    hsync_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? H_POL : ~H_POL;
    vsync_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? V_POL : ~V_POL;
  end

  // Position, decoded outputs and frame counter. Everything holds while
  // en_in is low except the strobes, which drop to 0.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      blank_out       <= 1'b0;
      hsync_out       <= ~H_POL;
      vsync_out       <= ~V_POL;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
      frame_count_out <= '0;
    end else if (en_in) begin
      hcount_out      <= h_next;
      vcount_out      <= v_next;
      blank_out       <= blank_next;
      hsync_out       <= hsync_next;
      vsync_out       <= vsync_next;
      line_start_out  <= h_wrap;
      frame_start_out <= frame_wrap;
      if (frame_wrap) frame_count_out <= frame_count_out + F_W'(1);
    end else begin
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a small raster: 15 x 9 total,
// H_POL=1 and V_POL=0. A frame is short, so wraps and frame-count
// rollover are reachable quickly.
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;  // 15
  localparam int VT = VA + VFP + VS + VBP;  // 9
  localparam int FW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] hcount, vcount;
  logic       hsync, vsync, blank, line_start, frame_start;
  logic [FW-1:0] frame_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: linear pixel index within the frame plus frame count.
  int m_p  = 0;
  int m_fc = 0;
  int m_ls = 0;
  int m_fs = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b1), .V_POL(1'b0), .H_W(4), .V_W(4), .F_W(FW)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst), .en_in(en),
    .hcount_out(hcount), .vcount_out(vcount),
    .hsync_out(hsync), .vsync_out(vsync), .blank_out(blank),
    .line_start_out(line_start), .frame_start_out(frame_start),
    .frame_count_out(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n, h, v, blank, hs, vs, ls, fs, fc;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic e);
    if (e) begin
      m_p  = (m_p + 1) % (HT * VT);
      if (m_p == 0) m_fc = (m_fc + 1) % (1 << FW);
      m_ls = (m_p % HT == 0) ? 1 : 0;
      m_fs = (m_p == 0) ? 1 : 0;
    end else begin
      m_ls = 0;
      m_fs = 0;
    end
  endtask

  // Apply one clock with en=e, then sample #1 after the edge.
  task automatic step(input logic e);
    @(negedge clk);
    en = e;
    @(posedge clk);
    #1;
    model_step(e);
  endtask

  task automatic chk_model(input string tag);
    int h, v;
    h = m_p % HT;
    v = m_p / HT;
    chk({tag, ".h"},     int'(hcount), h);
    chk({tag, ".v"},     int'(vcount), v);
    chk({tag, ".blank"}, int'(blank), (h >= HA || v >= VA) ? 1 : 0);
    chk({tag, ".hsync"}, int'(hsync), (h >= HA + HFP && h < HA + HFP + HS) ? 1 : 0);
    chk({tag, ".vsync"}, int'(vsync), (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1);
    chk({tag, ".ls"},    int'(line_start), m_ls);
    chk({tag, ".fs"},    int'(frame_start), m_fs);
    chk({tag, ".fc"},    int'(frame_count), m_fc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".h"},     int'(hcount), 0);
    chk({tag, ".v"},     int'(vcount), 0);
    chk({tag, ".blank"}, int'(blank), 0);
    chk({tag, ".hsync"}, int'(hsync), 0);
    chk({tag, ".vsync"}, int'(vsync), 1);
    chk({tag, ".ls"},    int'(line_start), 0);
    chk({tag, ".fs"},    int'(frame_start), 0);
    chk({tag, ".fc"},    int'(frame_count), 0);
  endtask

  initial begin
    // n edges, then expected {h, v, blank, hs, vs, ls, fs, fc}
    tbl[0]  = '{1,  1,  0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{7,  8,  0, 1, 0, 1, 0, 0, 0};  // blank rises at H_ACTIVE
    tbl[2]  = '{1,  9,  0, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{1,  10, 0, 1, 1, 1, 0, 0, 0};  // hsync first pixel
    tbl[4]  = '{2,  12, 0, 1, 1, 1, 0, 0, 0};  // hsync last pixel
    tbl[5]  = '{1,  13, 0, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{2,  0,  1, 0, 0, 1, 1, 0, 0};  // line wrap, blank falls
    tbl[7]  = '{1,  1,  1, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{59, 0,  5, 1, 0, 1, 1, 0, 0};  // first blanked line
    tbl[9]  = '{15, 0,  6, 1, 0, 0, 1, 0, 0};  // vsync line start
    tbl[10] = '{29, 14, 7, 1, 0, 0, 0, 0, 0};  // vsync last pixel
    tbl[11] = '{1,  0,  8, 1, 0, 1, 1, 0, 0};
    tbl[12] = '{14, 14, 8, 1, 0, 1, 0, 0, 0};
    tbl[13] = '{1,  0,  0, 0, 0, 1, 1, 1, 1};  // frame wrap
    tbl[14] = '{1,  1,  0, 0, 0, 1, 0, 0, 1};

    // Reset held with clock running and en high.
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;

    // Directed table walk across the frame boundaries.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(1'b1);
      chk($sformatf("tbl%0d.h", i),     int'(hcount),      tbl[i].h);
      chk($sformatf("tbl%0d.v", i),     int'(vcount),      tbl[i].v);
      chk($sformatf("tbl%0d.blank", i), int'(blank),       tbl[i].blank);
      chk($sformatf("tbl%0d.hsync", i), int'(hsync),       tbl[i].hs);
      chk($sformatf("tbl%0d.vsync", i), int'(vsync),       tbl[i].vs);
      chk($sformatf("tbl%0d.ls", i),    int'(line_start),  tbl[i].ls);
      chk($sformatf("tbl%0d.fs", i),    int'(frame_start), tbl[i].fs);
      chk($sformatf("tbl%0d.fc", i),    int'(frame_count), tbl[i].fc);
    end

    // Hold on a line start: strobes drop, position holds, then resume.
    for (int k = 0; k < 13; k++) step(1'b1);   // to (14,0)
    step(1'b1);                                 // (0,1) with line strobe
    chk("hold_pre.ls", int'(line_start), 1);
    step(1'b0);
    step(1'b0);
    chk("hold.h",  int'(hcount), 0);
    chk("hold.v",  int'(vcount), 1);
    chk("hold.ls", int'(line_start), 0);
    chk("hold.fc", int'(frame_count), 1);
    step(1'b1);
    chk("resume.h", int'(hcount), 1);
    chk("resume.v", int'(vcount), 1);

    // Asynchronous reset mid-frame, between edges.
    for (int k = 0; k < 40; k++) step(1'b1);
    chk_model("pre_arst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    m_p = 0; m_fc = 0; m_ls = 0; m_fs = 0;
    step(1'b0);
    chk_reset_vals("arst_idle");
    step(1'b1);
    chk("restart.h",  int'(hcount), 1);
    chk("restart.v",  int'(vcount), 0);
    chk("restart.fs", int'(frame_start), 0);
    chk("restart.fc", int'(frame_count), 0);

    // Random enable against the model; enough enabled steps to roll fc.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)));
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
